hw_sensor_req_sequencer: RTL and testbench

//   Sequencer for SDM sensor queries: walks all voltage channels, then every requested

---
 rtl/hw_sensor_req_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_hw_sensor_req_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hw_sensor_req_sequencer.sv
// Walks every voltage channel, then each requested temperature sensor, issuing one 2-beat
// mailbox command per entry and qualifying the response checker until the response EOP.
module hw_sensor_req_sequencer #(
  parameter int unsigned P_NO_CH_VOLT     = 9,
  parameter int unsigned P_NO_CH_TEMP     = 5,
  parameter logic [51:0] P_REQ_TEMPSENS   = {{8{4'd13}}, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0},
  parameter logic [7:0]  P_VOLT_OPCODE    = 8'h18,
  parameter logic [7:0]  P_TEMP_OPCODE    = 8'h19,
  parameter int unsigned P_TIMEOUT_CYCLES = 100000,
  parameter int unsigned P_PERIOD_CYCLES  = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable_i,
  output logic                    cmd_valid_o,
  input  logic                    cmd_ready_i,
  output logic [31:0]             cmd_data_o,
  output logic                    cmd_startofpacket_o,
  output logic                    cmd_endofpacket_o,
  input  logic                    rsp_valid_i,
  input  logic                    rsp_ready_i,
  input  logic                    rsp_endofpacket_i,
  output logic                    is_volt,
  output logic                    is_temp,
  output logic [P_NO_CH_VOLT-1:0] current_voltage_channel,
  output logic [3:0]              current_temperature_channel,
  output logic                    scan_done_o,
  output logic [15:0]             scan_count_o,
  output logic                    timeout_err_o,
  output logic [4:0]              timeout_chan_o
);

  localparam int unsigned LP_TEMP_ENTRIES = 13;
  localparam logic [3:0]  LP_UNUSED_ID    = 4'd13;
  localparam logic [23:0] LP_BEAT0_HI     = {8'h00, 12'h001, 4'h0};
  localparam int unsigned LP_CNT_MAX      = (P_TIMEOUT_CYCLES > P_PERIOD_CYCLES) ?
                                            P_TIMEOUT_CYCLES : P_PERIOD_CYCLES;
  localparam int unsigned LP_CNT_W        = $clog2(LP_CNT_MAX + 1);

  typedef logic [P_NO_CH_VOLT-1:0] vmask_t;
  typedef logic [LP_CNT_W-1:0]     cnt_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_ARG  = 3'd2,
    S_WAIT = 3'd3,
    S_NEXT = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  state_t      r_state, w_state;
  cnt_t        r_cnt, w_cnt;
  logic        r_ph_temp, w_ph_temp;
  logic [3:0]  r_idx, w_idx;
  logic [3:0]  r_tcnt, w_tcnt;
  logic        r_valid, w_valid;
  logic [31:0] r_data, w_data;
  logic        r_sop, w_sop;
  logic        r_eop, w_eop;
  logic        r_is_volt, w_is_volt;
  logic        r_is_temp, w_is_temp;
  vmask_t      r_vch, w_vch;
  logic [3:0]  r_tch, w_tch;
  logic        r_done, w_done;
  logic [15:0] r_scnt, w_scnt;
  logic        r_err, w_err;
  logic [4:0]  r_tchan, w_tchan;

  logic        w_rsp_eop;
  logic        w_found;
  logic [3:0]  w_found_idx;
  int          w_lb;
  logic        w_more;
  logic        w_more_temp;
  logic [3:0]  w_more_idx;
  logic [3:0]  w_sensor;

  assign w_rsp_eop = rsp_valid_i & rsp_ready_i & rsp_endofpacket_i;

  // Successor of the current entry; unused (id 13) temperature slots are skipped.
  always_comb begin
    w_found     = 1'b0;
    w_found_idx = 4'd0;
    w_more      = 1'b0;
    w_more_temp = 1'b0;
    w_more_idx  = 4'd0;
    w_lb        = r_ph_temp ? int'(r_idx) + 1 : 0;
    for (int i = int'(LP_TEMP_ENTRIES) - 1; i >= 0; i--) begin
      if (i >= w_lb && P_REQ_TEMPSENS[4*i +: 4] != LP_UNUSED_ID) begin
        w_found     = 1'b1;
        w_found_idx = 4'(i);
      end
    end
    if (!r_ph_temp && 32'(r_idx) < P_NO_CH_VOLT - 1) begin
      w_more     = 1'b1;
      w_more_idx = r_idx + 4'd1;
    end else if (w_found && 32'(r_tcnt) < P_NO_CH_TEMP) begin
      w_more      = 1'b1;
      w_more_temp = 1'b1;
      w_more_idx  = w_found_idx;
    end
  end

  // Sensor id of the entry about to be loaded into HDR.
  always_comb begin
    w_sensor = 4'd0;
    for (int i = 0; i < int'(LP_TEMP_ENTRIES); i++) begin
      if (4'(i) == w_idx) w_sensor = P_REQ_TEMPSENS[4*i +: 4];
    end
  end

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_ph_temp = r_ph_temp;
    w_idx     = r_idx;
    w_tcnt    = r_tcnt;
    w_valid   = r_valid;
    w_data    = r_data;
    w_sop     = r_sop;
    w_eop     = r_eop;
    w_is_volt = r_is_volt;
    w_is_temp = r_is_temp;
    w_vch     = r_vch;
    w_tch     = r_tch;
    w_done    = 1'b0;
    w_scnt    = r_scnt;
    w_err     = r_err;
    w_tchan   = r_tchan;

    case (r_state)
      S_IDLE: begin
        if (enable_i) begin
          w_state   = S_HDR;
          w_ph_temp = 1'b0;
          w_idx     = 4'd0;
          w_tcnt    = 4'd0;
        end
      end
      S_HDR: begin
        if (cmd_ready_i) begin
          w_state = S_ARG;
          w_data  = r_ph_temp ? {28'h0, r_tch} : 32'(r_vch);
          w_sop   = 1'b0;
          w_eop   = 1'b1;
        end
      end
      S_ARG: begin
        if (cmd_ready_i) begin
          w_state = S_WAIT;
          w_valid = 1'b0;
          w_eop   = 1'b0;
          w_data  = 32'h0;
          w_cnt   = '0;
        end
      end
      S_WAIT: begin
        // A response EOP wins over a timeout expiring in the same cycle.
        if (w_rsp_eop || r_cnt == cnt_t'(P_TIMEOUT_CYCLES - 1)) begin
          w_state   = S_NEXT;
          w_is_volt = 1'b0;
          w_is_temp = 1'b0;
          w_vch     = '0;
          w_tch     = 4'd0;
          if (!w_rsp_eop) begin
            w_err   = 1'b1;
            w_tchan = {r_ph_temp, r_idx};
          end
          if (!w_more) begin
            w_done = 1'b1;
            w_scnt = r_scnt + 16'd1;
          end
        end else begin
          w_cnt = r_cnt + cnt_t'(1);
        end
      end
      S_NEXT: begin
        if (!enable_i) begin
          w_state = S_IDLE;
        end else if (!w_more) begin
          w_state = S_GAP;
          w_cnt   = '0;
        end else begin
          w_state   = S_HDR;
          w_ph_temp = w_more_temp;
          w_idx     = w_more_idx;
          if (w_more_temp) w_tcnt = r_tcnt + 4'd1;
        end
      end
      S_GAP: begin
        if (!enable_i) begin
          w_state = S_IDLE;
        end else if (r_cnt == cnt_t'(P_PERIOD_CYCLES - 1)) begin
          w_state   = S_HDR;
          w_ph_temp = 1'b0;
          w_idx     = 4'd0;
          w_tcnt    = 4'd0;
        end else begin
          w_cnt = r_cnt + cnt_t'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Entering HDR: present beat0 and qualify the checker for the selected entry.
    if (w_state == S_HDR && r_state != S_HDR) begin
      w_valid   = 1'b1;
      w_sop     = 1'b1;
      w_eop     = 1'b0;
      w_data    = {LP_BEAT0_HI, w_ph_temp ? P_TEMP_OPCODE : P_VOLT_OPCODE};
      w_is_volt = ~w_ph_temp;
      w_is_temp = w_ph_temp;
      w_vch     = w_ph_temp ? '0 : (vmask_t'(1) << w_idx);
      w_tch     = w_ph_temp ? w_sensor : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ph_temp <= 1'b0;
      r_idx     <= 4'd0;
      r_tcnt    <= 4'd0;
      r_valid   <= 1'b0;
      r_data    <= 32'h0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_is_volt <= 1'b0;
      r_is_temp <= 1'b0;
      r_vch     <= '0;
      r_tch     <= 4'd0;
      r_done    <= 1'b0;
      r_scnt    <= 16'd0;
      r_err     <= 1'b0;
      r_tchan   <= 5'd0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_ph_temp <= w_ph_temp;
      r_idx     <= w_idx;
      r_tcnt    <= w_tcnt;
      r_valid   <= w_valid;
      r_data    <= w_data;
      r_sop     <= w_sop;
      r_eop     <= w_eop;
      r_is_volt <= w_is_volt;
      r_is_temp <= w_is_temp;
      r_vch     <= w_vch;
      r_tch     <= w_tch;
      r_done    <= w_done;
      r_scnt    <= w_scnt;
      r_err     <= w_err;
      r_tchan   <= w_tchan;
    end
  end

  assign cmd_valid_o                 = r_valid;
  assign cmd_data_o                  = r_data;
  assign cmd_startofpacket_o         = r_sop;
  assign cmd_endofpacket_o           = r_eop;
  assign is_volt                     = r_is_volt;
  assign is_temp                     = r_is_temp;
  assign current_voltage_channel     = r_vch;
  assign current_temperature_channel = r_tch;
  assign scan_done_o                 = r_done;
  assign scan_count_o                = r_scnt;
  assign timeout_err_o               = r_err;
  assign timeout_chan_o              = r_tchan;

endmodule

// File: tb/tb_hw_sensor_req_sequencer.sv
// Directed bench: full scans, ready back-pressure, response timeout, sparse sensor table,
// enable drop mid-transaction and reset during the argument beat.
module tb_hw_sensor_req_sequencer;

  localparam int unsigned LP_NV  = 9;
  localparam int unsigned LP_TO  = 20;
  localparam int unsigned LP_PER = 30;
  localparam logic [51:0] LP_TS1 = {{10{4'd13}}, 4'd7, 4'd13, 4'd2};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en0 = 1'b0;
  logic en1 = 1'b0;
  logic sel = 1'b0;
  logic cmd_ready_i = 1'b1;
  logic rsp_valid_i = 1'b0;
  logic rsp_ready_i = 1'b0;
  logic rsp_eop_i = 1'b0;

  logic d0_valid, d0_sop, d0_eop, d0_isv, d0_ist, d0_done, d0_err;
  logic d1_valid, d1_sop, d1_eop, d1_isv, d1_ist, d1_done, d1_err;
  logic [31:0] d0_data, d1_data;
  logic [LP_NV-1:0] d0_vch, d1_vch;
  logic [3:0] d0_tch, d1_tch;
  logic [15:0] d0_cnt, d1_cnt;
  logic [4:0] d0_tchan, d1_tchan;

  logic m_valid, m_sop, m_eop, m_isv, m_ist, m_done, m_err;
  logic [31:0] m_data;
  logic [LP_NV-1:0] m_vch;
  logic [3:0] m_tch;
  logic [15:0] m_cnt;
  logic [4:0] m_tchan;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hw_sensor_req_sequencer #(
    .P_TIMEOUT_CYCLES(LP_TO),
    .P_PERIOD_CYCLES (LP_PER)
  ) u_dut0 (
    .clk                        (clk),
    .reset                      (reset),
    .enable_i                   (en0),
    .cmd_valid_o                (d0_valid),
    .cmd_ready_i                (cmd_ready_i),
    .cmd_data_o                 (d0_data),
    .cmd_startofpacket_o        (d0_sop),
    .cmd_endofpacket_o          (d0_eop),
    .rsp_valid_i                (rsp_valid_i),
    .rsp_ready_i                (rsp_ready_i),
    .rsp_endofpacket_i          (rsp_eop_i),
    .is_volt                    (d0_isv),
    .is_temp                    (d0_ist),
    .current_voltage_channel    (d0_vch),
    .current_temperature_channel(d0_tch),
    .scan_done_o                (d0_done),
    .scan_count_o               (d0_cnt),
    .timeout_err_o              (d0_err),
    .timeout_chan_o             (d0_tchan)
  );

  hw_sensor_req_sequencer #(
    .P_NO_CH_TEMP    (2),
    .P_REQ_TEMPSENS  (LP_TS1),
    .P_TIMEOUT_CYCLES(LP_TO),
    .P_PERIOD_CYCLES (LP_PER)
  ) u_dut1 (
    .clk                        (clk),
    .reset                      (reset),
    .enable_i                   (en1),
    .cmd_valid_o                (d1_valid),
    .cmd_ready_i                (cmd_ready_i),
    .cmd_data_o                 (d1_data),
    .cmd_startofpacket_o        (d1_sop),
    .cmd_endofpacket_o          (d1_eop),
    .rsp_valid_i                (rsp_valid_i),
    .rsp_ready_i                (rsp_ready_i),
    .rsp_endofpacket_i          (rsp_eop_i),
    .is_volt                    (d1_isv),
    .is_temp                    (d1_ist),
    .current_voltage_channel    (d1_vch),
    .current_temperature_channel(d1_tch),
    .scan_done_o                (d1_done),
    .scan_count_o               (d1_cnt),
    .timeout_err_o              (d1_err),
    .timeout_chan_o             (d1_tchan)
  );

  assign m_valid = sel ? d1_valid : d0_valid;
  assign m_sop   = sel ? d1_sop   : d0_sop;
  assign m_eop   = sel ? d1_eop   : d0_eop;
  assign m_isv   = sel ? d1_isv   : d0_isv;
  assign m_ist   = sel ? d1_ist   : d0_ist;
  assign m_done  = sel ? d1_done  : d0_done;
  assign m_err   = sel ? d1_err   : d0_err;
  assign m_data  = sel ? d1_data  : d0_data;
  assign m_vch   = sel ? d1_vch   : d0_vch;
  assign m_tch   = sel ? d1_tch   : d0_tch;
  assign m_cnt   = sel ? d1_cnt   : d0_cnt;
  assign m_tchan = sel ? d1_tchan : d0_tchan;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl();
    return {29'd0, m_valid, m_sop, m_eop};
  endfunction

  function automatic logic [31:0] qual();
    return {16'd0, m_isv, m_ist, 1'b0, m_tch, m_vch};
  endfunction

  function automatic logic [31:0] stat();
    return {10'd0, m_done, m_cnt, m_err, 4'd0} ^ {27'd0, m_tchan};
  endfunction

  // One command/response exchange for entry k (channel or sensor id).
  task automatic txn(input bit t, input logic [3:0] k, input int stall, input bit give_eop,
                     input bit drop_en);
    logic [31:0] b0, b1, q;
    logic [LP_NV-1:0] oh;
    int n;
    oh = t ? '0 : (LP_NV'(1) << k);
    b0 = {8'h00, 12'h001, 4'h0, t ? 8'h19 : 8'h18};
    b1 = t ? {28'h0, k} : 32'(oh);
    q  = {16'd0, ~t, t, 1'b0, t ? k : 4'd0, oh};
    n = 0;
    while (!m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (stall > 0) cmd_ready_i = 1'b0;
    chk("beat0_ctl", ctl(), 32'd6);
    chk("beat0_data", m_data, b0);
    chk("hdr_qual", qual(), q);
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      chk("beat0_hold_ctl", ctl(), 32'd6);
      chk("beat0_hold_data", m_data, b0);
      cmd_ready_i = 1'b1;
    end
    @(negedge clk);
    chk("beat1_ctl", ctl(), 32'd5);
    chk("beat1_data", m_data, b1);
    if (stall > 0) begin
      cmd_ready_i = 1'b0;
      repeat (stall) @(negedge clk);
      chk("beat1_hold_ctl", ctl(), 32'd5);
      chk("beat1_hold_data", m_data, b1);
      cmd_ready_i = 1'b1;
    end
    @(negedge clk);
    chk("wait_bus_idle", ctl(), 32'd0);
    if (drop_en) begin
      en0 = 1'b0;
      en1 = 1'b0;
    end
    if (give_eop) begin
      repeat (3) @(negedge clk);
      chk("wait_qual_held", qual(), q);
      rsp_valid_i = 1'b1;
      rsp_ready_i = 1'b1;
      rsp_eop_i   = 1'b1;
      @(negedge clk);
      rsp_valid_i = 1'b0;
      rsp_ready_i = 1'b0;
      rsp_eop_i   = 1'b0;
    end else begin
      repeat (LP_TO - 1) @(negedge clk);
      chk("pre_timeout", {30'd0, m_err, m_isv}, {30'd0, 1'b0, ~t});
      @(negedge clk);
      chk("timeout_err", 32'(m_err), 32'd1);
      chk("timeout_chan", 32'(m_tchan), 32'({t, k}));
    end
    chk("qual_cleared", qual(), 32'd0);
  endtask

  initial begin
    int n;
    int hits;
    repeat (3) @(negedge clk);
    chk("reset_ctl", ctl(), 32'd0);
    chk("reset_data", m_data, 32'd0);
    chk("reset_qual", qual(), 32'd0);
    chk("reset_stat", stat(), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    en0 = 1'b1;

    // Scan 1: plain traffic.
    for (int c = 0; c < 9; c++) txn(1'b0, 4'(c), 0, 1'b1, 1'b0);
    for (int s = 0; s < 5; s++) txn(1'b1, 4'(s), 0, 1'b1, 1'b0);
    chk("scan1_done", {15'd0, m_done, m_cnt}, {15'd0, 1'b1, 16'd1});
    @(negedge clk);
    chk("scan1_done_pulse", 32'(m_done), 32'd0);
    n = 0;
    while (!m_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("gap_length", 32'(n), 32'(LP_PER));
    chk("gap_restart_ch0", 32'(m_vch), 32'd1);

    // Scan 2: back-pressure on ch0, withheld response on ch4.
    txn(1'b0, 4'd0, 5, 1'b1, 1'b0);
    for (int c = 1; c < 4; c++) txn(1'b0, 4'(c), 0, 1'b1, 1'b0);
    txn(1'b0, 4'd4, 0, 1'b0, 1'b0);
    for (int c = 5; c < 9; c++) txn(1'b0, 4'(c), 0, 1'b1, 1'b0);
    for (int s = 0; s < 5; s++) txn(1'b1, 4'(s), 0, 1'b1, 1'b0);
    chk("scan2_done", {14'd0, m_err, m_done, m_cnt}, {14'd0, 1'b1, 1'b1, 16'd2});

    // Scan 3: enable dropped while waiting on ch3.
    for (int c = 0; c < 3; c++) txn(1'b0, 4'(c), 0, 1'b1, 1'b0);
    txn(1'b0, 4'd3, 0, 1'b1, 1'b1);
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (m_valid) hits++;
    end
    chk("disabled_no_cmd", 32'(hits), 32'd0);
    chk("disabled_qual", qual(), 32'd0);
    chk("disabled_stat", {15'd0, m_err, m_cnt}, {15'd0, 1'b1, 16'd2});

    // Reset while the argument beat is on the bus.
    en0 = 1'b1;
    @(negedge clk);
    chk("t6_hdr", ctl(), 32'd6);
    @(negedge clk);
    chk("t6_arg", ctl(), 32'd5);
    reset = 1'b1;
    en0 = 1'b0;
    @(negedge clk);
    chk("t6_ctl", ctl(), 32'd0);
    chk("t6_qual", qual(), 32'd0);
    chk("t6_stat", stat(), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Sparse sensor table on the second instance.
    sel = 1'b1;
    en1 = 1'b1;
    for (int c = 0; c < 9; c++) txn(1'b0, 4'(c), 0, 1'b1, 1'b0);
    txn(1'b1, 4'd2, 0, 1'b1, 1'b0);
    txn(1'b1, 4'd7, 0, 1'b1, 1'b0);
    chk("t4_scan_done", {15'd0, m_done, m_cnt}, {15'd0, 1'b1, 16'd1});
    en1 = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
